// File: rtl/joy_source_arbiter_pkg.sv
// Shared types and constants for the joystick source arbiter.
// State encoding, direction bit masks and pipeline mode codes; no logic.
package joy_source_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_OWNED,
    ST_RELEASE
  } state_t;

  // Direction nibble layout is {up,down,left,right}
  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_UP    = 4'b1000;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b0010;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;

  localparam logic [3:0] MODE_DISABLED   = 4'd0;
  localparam logic [3:0] MODE_NORMAL     = 4'd1;
  localparam logic [3:0] MODE_CORRECTION = 4'd2;
  localparam logic [3:0] MODE_FOURWAY    = 4'd3;

endpackage

// File: rtl/joy_src_prio_enc.sv
// Lowest-index non-zero source finder; combinational, zero latency, no flow control.
// index is 0 when no source is active, so always qualify it with any.
module joy_src_prio_enc
  import joy_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  localparam int IW = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC*4-1:0] src_dir,
  output logic [IW-1:0]        index,
  output logic                 any
);

  always_comb begin
    index = '0;
    any   = 1'b0;
    // Descending scan so the lowest active index is the last assignment
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_dir[4*i +: 4] != DIR_NONE) begin
        index = IW'(i);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/joy_source_arbiter.sv
// Grants one directional source ownership of the joy pipeline after a settle check.
// dirout follows the owner with 1-cycle latency; mode changes wait until every input is idle.
module joy_source_arbiter
  import joy_source_arbiter_pkg::*;
#(
  parameter int NUM_SRC       = 3,
  parameter int SETTLE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 48000,
  localparam int IW = $clog2(NUM_SRC),
  localparam int SW = $clog2(SETTLE_CYCLES + 1),
  localparam int HW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_SRC*4-1:0] src_dir,
  input  logic [3:0]           mode_in,
  input  logic                 mode_req,
  output logic [3:0]           dirout,
  output logic [3:0]           mode_out,
  output logic [IW-1:0]        owner,
  output logic                 owner_vld,
  output logic                 mode_busy
);

  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] SETTLE_SAT  = SW'(SETTLE_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_SAT    = HW'(HOLD_CYCLES);

  state_t          state;
  logic [IW-1:0]   cand;
  logic [SW-1:0]   settle_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [3:0]      pend;
  logic [IW-1:0]   first_idx;
  logic            any_active;
  logic [3:0]      cand_dir;
  logic [3:0]      owner_dir;

  joy_src_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio_enc (
    .src_dir (src_dir),
    .index   (first_idx),
    .any     (any_active)
  );

  assign cand_dir  = src_dir[{cand, 2'b00} +: 4];
  assign owner_dir = src_dir[{owner, 2'b00} +: 4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cand       <= '0;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      dirout     <= DIR_NONE;
      owner      <= '0;
      owner_vld  <= 1'b0;
      pend       <= MODE_DISABLED;
      mode_out   <= MODE_DISABLED;
      mode_busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          dirout <= DIR_NONE;
          if (any_active) begin
            cand       <= first_idx;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          dirout <= DIR_NONE;
          if (cand_dir == DIR_NONE) begin
            state <= ST_IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state     <= ST_OWNED;
            owner     <= cand;
            owner_vld <= 1'b1;
            dirout    <= cand_dir;
          end else if (settle_cnt != SETTLE_SAT) begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        ST_OWNED: begin
          dirout <= owner_dir;
          if (owner_dir == DIR_NONE) begin
            state    <= ST_RELEASE;
            hold_cnt <= '0;
          end
        end
        ST_RELEASE: begin
          // A re-press by the owner beats the timeout, even on the last hold cycle
          dirout <= owner_dir;
          if (owner_dir != DIR_NONE) begin
            state <= ST_OWNED;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= ST_IDLE;
            owner_vld <= 1'b0;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          dirout    <= DIR_NONE;
          owner_vld <= 1'b0;
        end
      endcase

      // Apply the old pending mode first; a same-cycle request re-arms busy after it
      if (mode_busy && state == ST_IDLE && !any_active) begin
        mode_out  <= pend;
        mode_busy <= 1'b0;
      end
      if (mode_req) begin
        pend      <= mode_in;
        mode_busy <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_joy_source_arbiter.sv
// Scoreboard bench: driver pushes model predictions per clock edge, a negedge monitor pops and compares.
module tb_joy_source_arbiter;
  import joy_source_arbiter_pkg::*;

  localparam int NS = 3;
  localparam int SETTLE = 4;
  localparam int HOLD = 8;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [11:0] src_dir;
  logic [3:0]  mode_in;
  logic        mode_req;
  logic [3:0]  dirout;
  logic [3:0]  mode_out;
  logic [1:0]  owner;
  logic        owner_vld;
  logic        mode_busy;

  joy_source_arbiter #(.NUM_SRC(NS), .SETTLE_CYCLES(SETTLE), .HOLD_CYCLES(HOLD)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .src_dir   (src_dir),
    .mode_in   (mode_in),
    .mode_req  (mode_req),
    .dirout    (dirout),
    .mode_out  (mode_out),
    .owner     (owner),
    .owner_vld (owner_vld),
    .mode_busy (mode_busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [3:0] dir;
    int         own;
    bit         vld;
    logic [3:0] mode;
    bit         busy;
  } exp_t;

  exp_t q[$];
  int edge_cnt = 0;
  int checks = 0;
  int failures = 0;

  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Reference model: ownership expressed as timestamps of when settling/release began
  bit         m_vld;
  int         m_own;
  int         m_cand;
  int         m_cand_since;
  int         m_rel_since;
  logic [3:0] m_mode;
  logic [3:0] m_pend;
  bit         m_busy;

  task automatic model_reset();
    m_vld = 0; m_own = 0; m_cand = -1; m_cand_since = 0; m_rel_since = -1;
    m_mode = MODE_DISABLED; m_pend = MODE_DISABLED; m_busy = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic model_step(input int n, input logic [11:0] s, input bit req, input logic [3:0] mi);
    exp_t e;
    logic [3:0] d;
    int first;
    bit idle_now;
    idle_now = !m_vld && (m_cand < 0);
    if (m_busy && idle_now && s == 12'd0) begin
      m_mode = m_pend;
      m_busy = 0;
    end
    if (req) begin
      m_pend = mi;
      m_busy = 1;
    end
    d = 4'd0;
    if (m_vld) begin
      if (s[4*m_own +: 4] != 4'd0) begin
        m_rel_since = -1;
        d = s[4*m_own +: 4];
      end else if (m_rel_since < 0) begin
        m_rel_since = n;
      end else if (n - m_rel_since == HOLD) begin
        m_vld = 0;
      end
    end else if (m_cand >= 0) begin
      if (s[4*m_cand +: 4] == 4'd0) begin
        m_cand = -1;
      end else if (n - m_cand_since == SETTLE) begin
        m_own = m_cand; m_vld = 1; m_cand = -1; m_rel_since = -1;
        d = s[4*m_own +: 4];
      end
    end else begin
      first = -1;
      for (int i = NS - 1; i >= 0; i--) if (s[4*i +: 4] != 4'd0) first = i;
      if (first >= 0) begin
        m_cand = first;
        m_cand_since = n;
      end
    end
    e.cyc = n; e.dir = d; e.own = m_own; e.vld = m_vld; e.mode = m_mode; e.busy = m_busy;
    q.push_back(e);
  endtask

  task automatic step(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                      input bit req, input logic [3:0] mi);
    src_dir = {s2, s1, s0};
    mode_req = req;
    mode_in = mi;
    model_step(edge_cnt + 1, {s2, s1, s0}, req, mi);
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2, input int cycles);
    for (int k = 0; k < cycles; k++) step(s0, s1, s2, 1'b0, 4'd0);
  endtask

  always @(negedge clock) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc < edge_cnt) begin
      e = q.pop_front();
      failures++;
      $display("FAIL stale_entry edge=%0d got=none expected=entry_for_edge_%0d", edge_cnt, e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == edge_cnt) begin
      e = q.pop_front();
      chk("dirout", int'(dirout), int'(e.dir));
      chk("owner_vld", int'(owner_vld), int'(e.vld));
      if (e.vld) chk("owner", int'(owner), e.own);
      chk("mode_out", int'(mode_out), int'(e.mode));
      chk("mode_busy", int'(mode_busy), int'(e.busy));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog edge=%0d got=timeout expected=finish", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] cur [NS];
    bit req;
    reset_n = 1'b0;
    src_dir = '0;
    mode_in = '0;
    mode_req = 1'b0;
    model_reset();
    #12;
    chk("reset_dirout", int'(dirout), 0);
    chk("reset_owner_vld", int'(owner_vld), 0);
    chk("reset_owner", int'(owner), 0);
    chk("reset_mode_out", int'(mode_out), int'(MODE_DISABLED));
    chk("reset_mode_busy", int'(mode_busy), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Grant after settle, non-owner ignored, release window then hand-over
    hold(4'd0, DIR_UP, 4'd0, 10);
    hold(4'd0, DIR_UP, DIR_LEFT, 3);
    hold(4'd0, 4'd0, DIR_LEFT, 16);
    hold(4'd0, 4'd0, 4'd0, 12);
    // Re-press at hold=5 resumes ownership without settling
    hold(4'd0, DIR_DOWN, 4'd0, 6);
    hold(4'd0, 4'd0, 4'd0, 6);
    hold(4'd0, DIR_DOWN, 4'd0, 3);
    // Re-press exactly on the timeout edge
    hold(4'd0, 4'd0, 4'd0, 8);
    hold(4'd0, DIR_RIGHT, 4'd0, 2);
    hold(4'd0, 4'd0, 4'd0, 12);
    // Simultaneous arrival and a settle glitch
    hold(DIR_UP, 4'd0, DIR_RIGHT, 6);
    hold(4'd0, 4'd0, 4'd0, 12);
    hold(DIR_UP, 4'd0, 4'd0, 2);
    hold(4'd0, 4'd0, 4'd0, 1);
    hold(DIR_UP, 4'd0, 4'd0, 2);
    hold(4'd0, 4'd0, 4'd0, 4);
    // Mode request deferred until release, timeout and idle inputs
    hold(DIR_RIGHT, 4'd0, 4'd0, 6);
    step(DIR_RIGHT, 4'd0, 4'd0, 1'b1, MODE_CORRECTION);
    hold(DIR_RIGHT, 4'd0, 4'd0, 3);
    hold(4'd0, 4'd0, 4'd0, 12);
    // Overwrite while busy, and a request landing on the apply cycle
    hold(4'd0, DIR_LEFT, 4'd0, 3);
    step(4'd0, DIR_LEFT, 4'd0, 1'b1, MODE_NORMAL);
    step(4'd0, DIR_LEFT, 4'd0, 1'b1, MODE_FOURWAY);
    hold(4'd0, 4'd0, 4'd0, 2);
    step(4'd0, 4'd0, 4'd0, 1'b1, MODE_CORRECTION);
    hold(4'd0, 4'd0, 4'd0, 3);

    // Asynchronous reset while owned, with a mode pending
    hold(DIR_LEFT, 4'd0, 4'd0, 7);
    step(DIR_LEFT, 4'd0, 4'd0, 1'b1, MODE_NORMAL);
    @(negedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst_dirout", int'(dirout), 0);
    chk("arst_owner_vld", int'(owner_vld), 0);
    chk("arst_mode_out", int'(mode_out), int'(MODE_DISABLED));
    chk("arst_mode_busy", int'(mode_busy), 0);
    src_dir = '0;
    mode_req = 1'b0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    hold(4'd0, 4'd0, 4'd0, 3);

    // Randomized traffic
    for (int i = 0; i < NS; i++) cur[i] = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NS; i++) begin
        if ($urandom_range(0, 11) == 0)
          cur[i] = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
      end
      req = ($urandom_range(0, 19) == 0);
      step(cur[0], cur[1], cur[2], req, 4'($urandom_range(0, 15)));
    end
    hold(4'd0, 4'd0, 4'd0, 14);

    @(negedge clock);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
